// File: rtl/serdes_crypt_pkg.sv
// Shared types for the serial crypt core: FSM state encoding and combine-mode encodings.
package serdes_crypt_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT_IN  = 2'd1,
        COMPUTE   = 2'd2,
        SHIFT_OUT = 2'd3
    } state_e;

    localparam logic MODE_XOR = 1'b0;
    localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/serdes_shreg.sv
// WIDTH-bit left-shifting register with parallel load (load wins over shift) and an MSB tap.
import serdes_crypt_pkg::*;

module serdes_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift_en,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q,
    output logic             msb
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], shift_in};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/serdes_crypt_core.sv
// Serial-in / serial-out word combiner: shifts in plaintext and key, combines them, shifts the result out.
// Define SERDES_CRYPT_ADD_EN to compile in the modular-add path selected by mode; otherwise XOR only.
import serdes_crypt_pkg::*;

module serdes_crypt_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             a_bit,
    input  logic             b_bit,
    input  logic             mode,
    output logic [WIDTH-1:0] cipher_par,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] unused_out_word;
    logic             unused_a_msb;
    logic             unused_b_msb;
    logic             out_msb;
    logic             take_start;
    logic             in_shift;
    logic             in_compute;
    logic             out_shift;

    assign take_start = ena && (state == IDLE) && start;
    assign in_shift   = ena && (state == SHIFT_IN);
    assign in_compute = ena && (state == COMPUTE);
    assign out_shift  = ena && (state == SHIFT_OUT);

    // Operand registers are cleared at start so every word begins from a known value.
    serdes_shreg #(.WIDTH(WIDTH)) u_a_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (take_start),
        .load_val ('0),
        .shift_en (in_shift),
        .shift_in (a_bit),
        .q        (a_q),
        .msb      (unused_a_msb)
    );

    serdes_shreg #(.WIDTH(WIDTH)) u_b_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (take_start),
        .load_val ('0),
        .shift_en (in_shift),
        .shift_in (b_bit),
        .q        (b_q),
        .msb      (unused_b_msb)
    );

    // Separate copy for serialisation so cipher_par stays stable while bits go out.
    serdes_shreg #(.WIDTH(WIDTH)) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (in_compute),
        .load_val (result),
        .shift_en (out_shift),
        .shift_in (1'b0),
        .q        (unused_out_word),
        .msb      (out_msb)
    );

`ifdef SERDES_CRYPT_ADD_EN
    always_comb begin
        result = a_q ^ b_q;
        if (mode == MODE_ADD) begin
            result = a_q + b_q;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        result = a_q ^ b_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cipher_par <= '0;
            done       <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT_IN;
                        cnt   <= '0;
                    end
                end
                SHIFT_IN: begin
                    if (cnt == LAST) begin
                        state <= COMPUTE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMPUTE: begin
                    cipher_par <= result;
                    done       <= 1'b1;
                    state      <= SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign ser_valid = (state == SHIFT_OUT);
    assign ser_out   = ser_valid & out_msb;

endmodule

// File: tb/tb_serdes_crypt_core.sv
// Directed, table-driven bench for serdes_crypt_core at WIDTH=8 and WIDTH=16.
// Expected add results follow SERDES_CRYPT_ADD_EN; without it mode=1 must still give XOR.
module tb_serdes_crypt_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        start8;
    logic        start16;
    logic        a_bit;
    logic        b_bit;
    logic        mode;
    logic [7:0]  par8;
    logic        so8, sv8, bz8, dn8;
    logic [15:0] par16;
    logic        so16, sv16, bz16, dn16;

    int vectors;
    int miscompares;

`ifdef SERDES_CRYPT_ADD_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic [31:0] exp;
        int          restart_at;
        int          stall_at;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    serdes_crypt_core #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start8),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .mode       (mode),
        .cipher_par (par8),
        .ser_out    (so8),
        .ser_valid  (sv8),
        .busy       (bz8),
        .done       (dn8)
    );

    serdes_crypt_core #(.WIDTH(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start16),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .mode       (mode),
        .cipher_par (par16),
        .ser_out    (so16),
        .ser_valid  (sv16),
        .busy       (bz16),
        .done       (dn16)
    );

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic sample_outs(input int w, output logic [31:0] par, output logic so,
                               output logic sv, output logic bz, output logic dn);
        if (w == 16) begin
            par = 32'(par16); so = so16; sv = sv16; bz = bz16; dn = dn16;
        end else begin
            par = 32'(par8); so = so8; sv = sv8; bz = bz8; dn = dn8;
        end
    endtask

    task automatic pulse_start(input int w);
        if (w == 16) start16 = 1'b1;
        else         start8  = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        logic [31:0] par, ser;
        logic        so, sv, bz, dn;
        logic [3:0]  held;
        int          c, lat, busy_cnt, dones, nvalid;
        bit          timed_out;

        mode  = v.m;
        ena   = 1'b1;
        a_bit = 1'b0;
        b_bit = 1'b0;
        @(posedge clk); #1;
        pulse_start(v.w);
        @(posedge clk); #1;
        start8  = 1'b0;
        start16 = 1'b0;
        sample_outs(v.w, par, so, sv, bz, dn);
        busy_cnt  = bz ? 1 : 0;
        c         = 0;
        lat       = -1;
        dones     = 0;
        nvalid    = 0;
        ser       = '0;
        timed_out = 1'b1;
        while (c < 200) begin
            a_bit = (c < v.w) ? v.a[v.w-1-c] : 1'b0;
            b_bit = (c < v.w) ? v.b[v.w-1-c] : 1'b0;
            if (c == v.restart_at) pulse_start(v.w);
            @(posedge clk); #1;
            start8  = 1'b0;
            start16 = 1'b0;
            c++;
            sample_outs(v.w, par, so, sv, bz, dn);
            if (dn) begin
                dones++;
                if (lat < 0) lat = c;
            end
            if (sv) begin
                ser = {ser[30:0], so};
                nvalid++;
            end
            if (!bz) begin
                timed_out = 1'b0;
                break;
            end
            busy_cnt++;
            if (c == v.stall_at) begin
                held = {sv, so, dn, bz};
                ena  = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                sample_outs(v.w, par, so, sv, bz, dn);
                check_output({tag, " stall hold"}, 32'({sv, so, dn, bz}), 32'(held));
                ena = 1'b1;
            end
        end
        check_output({tag, " timeout"}, 32'(timed_out), 32'd0);
        check_output({tag, " cipher_par"}, par, v.exp);
        check_output({tag, " serial stream"}, ser, v.exp);
        check_output({tag, " done latency"}, 32'(lat), 32'(v.w + 1));
        check_output({tag, " busy cycles"}, 32'(busy_cnt), 32'(2 * v.w + 1));
        check_output({tag, " done pulses"}, 32'(dones), 32'd1);
        check_output({tag, " valid bits"}, 32'(nvalid), 32'(v.w));
        check_output({tag, " idle serial"}, 32'({sv, so}), 32'd0);
    endtask

    initial begin
        logic [31:0] par;
        logic        so, sv, bz, dn;
        int          stray_done;
        int          stray_busy;

        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        ena     = 1'b0;
        start8  = 1'b0;
        start16 = 1'b0;
        a_bit   = 1'b0;
        b_bit   = 1'b0;
        mode    = 1'b0;

        tbl[0] = '{8,  32'h02,   32'h03,   1'b0, 32'h01, -1, -1};
        tbl[1] = '{8,  32'hA5,   32'h5A,   1'b0, 32'hFF, -1, -1};
        tbl[2] = '{8,  32'hFF,   32'h01,   1'b1, ADD_EN ? 32'h00 : 32'hFE, -1, -1};
        tbl[3] = '{8,  32'h7F,   32'h01,   1'b1, ADD_EN ? 32'h80 : 32'h7E, -1, -1};
        tbl[4] = '{8,  32'h3C,   32'h0F,   1'b0, 32'h33, 3, -1};
        tbl[5] = '{8,  32'hC3,   32'h81,   1'b0, 32'h42, -1, 11};
        tbl[6] = '{8,  32'h55,   32'hFF,   1'b0, 32'hAA, -1, 9};
        tbl[7] = '{16, 32'h1234, 32'hFFFF, 1'b0, 32'hEDCB, -1, -1};
        tbl[8] = '{16, 32'hABCD, 32'h1111, 1'b1, ADD_EN ? 32'hBCDE : 32'hBADC, -1, 20};

        #12;
        check_output("reset dut8", 32'({par8, so8, sv8, bz8, dn8}), 32'd0);
        check_output("reset dut16", 32'({par16, so16, sv16, bz16, dn16}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // dut8 was idle during the 16-bit words and must still show its last result.
        check_output("dut8 result hold", 32'(par8), 32'hAA);

        // Abort a word with an asynchronous reset partway through shifting in.
        ena = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b1;
        a_bit  = 1'b1;
        b_bit  = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sample_outs(8, par, so, sv, bz, dn);
        check_output("async reset outputs", 32'({par[7:0], so, sv, bz, dn}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n      = 1'b1;
        stray_done = 0;
        stray_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (dn8) stray_done++;
            if (bz8) stray_busy++;
        end
        check_output("no done after abort", 32'(stray_done), 32'd0);
        check_output("idle after abort", 32'(stray_busy), 32'd0);
        apply_stimulus('{8, 32'hA5, 32'h5A, 1'b0, 32'hFF, -1, -1}, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
